sh7604_ibus_arb: RTL and testbench
==================================

Name: sh7604_ibus_arb

Overview:
- Internal-bus arbiter placed in front of the SH7604 bus state controller's IBUS slave port.
- Shares the single BSC port between three requesters: M0 = DMAC, M1 = CPU data access, M2 = CPU instruction fetch.
- Grants one master at a time and forwards its request to the BSC.
- Holds the grant across locked read-modify-write sequences and cache-line bursts, and returns BUSY to every non-granted requester.

Parameters:
- BURST_LEN, 4: beats per burst; the grant is held for this many completed transfers when BURST is set. Legal values: 2 or 4.
- FETCH_LAST, 1: when 1, M2 is always lowest priority, including in round-robin mode.

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CE_R  in  1  rising-phase clock enable; all state updates happen only on CLK edges with CE_R=1
- M_A  in  96  {M2,M1,M0} addresses, 32 bits each
- M_DI  in  96  {M2,M1,M0} write data
- M_BA  in  12  {M2,M1,M0} byte enables, 4 bits each
- M_WE  in  3  per-master write strobe
- M_REQ  in  3  per-master request
- M_BURST  in  3  per-master burst request
- M_LOCK  in  3  per-master bus lock
- M_DO  out  32  read data, broadcast to all masters (equals S_DO)
- M_BUSY  out  3  per-master stall
- M_GNT  out  3  one-hot current grant (debug/DMAC use)
- S_A  out  32  to BSC IBUS_A
- S_DI  out  32  to BSC IBUS_DI
- S_BA  out  4  to BSC IBUS_BA
- S_WE  out  1  to BSC IBUS_WE
- S_REQ  out  1  to BSC IBUS_REQ
- S_BURST  out  1  to BSC IBUS_BURST
- S_LOCK  out  1  to BSC IBUS_LOCK
- S_DO  in  32  from BSC IBUS_DO
- S_BUSY  in  1  from BSC IBUS_BUSY

Behaviour:
Clocking and reset
- Single clock CLK; reset RST is asynchronous and active-high.
- RST forces: state IDLE, GNT=000, BEAT_CNT=0, RR_PTR=0.
- While GNT=000, all S_* outputs are 0, M_BUSY=M_REQ, and M_GNT=000.

Output muxing (combinational from the registered GNT)
- S_* equals the granted master's signals.
- S_REQ = M_REQ[g] & (GNT != 0).
- M_BUSY[i] = M_REQ[i] & (~GNT[i] | S_BUSY).

Completion
- A transfer completes on a CE_R edge where the state is OWN, S_REQ=1 and S_BUSY=0.

States
- IDLE: on a CE_R edge with any M_REQ=1, load GNT with the winner and go to OWN. This costs one CE_R cycle of arbitration latency from idle.
- OWN, on completion:
  - If M_LOCK[g]=1: keep the grant.
  - Else if a burst is active and BEAT_CNT != BURST_LEN-1: increment BEAT_CNT and keep the grant.
  - Else: clear BEAT_CNT and re-arbitrate in the same edge. Go to OWN with the new winner if any request is pending (back-to-back, zero idle), else go to IDLE.
- Burst start: a burst becomes active on the first completion with M_BURST[g]=1 & M_WE[g]=0. BURST with WE=1 is treated as a single beat.
- Abort: in OWN, a CE_R edge with M_REQ[g]=0 and M_LOCK[g]=0 drops the grant (re-arbitrate or go to IDLE) and clears BEAT_CNT. LOCK=1 with REQ=0 keeps the grant (idle locked bus).

Priority (without the optional feature)
- Fixed order: M0 > M1 > M2.

Simultaneous events
- New requests arriving during a held grant wait, with BUSY=1.
- A lock asserted on the completing beat holds the grant.
- A request that drops in the same edge as arbitration is not granted; only requests sampled at that edge compete.

Masters
- Must hold A/DI/BA/WE stable while M_BUSY=1.
- GNT changes only on CE_R edges.

Optional Feature:
- Macro: SH7604_IBUS_ARB_RR_EN.
- Defined: round-robin among the eligible masters (M0/M1 only if FETCH_LAST=1, otherwise all three). RR_PTR is a 2-bit register that points past the last granted master and is updated on every grant release. M2 still loses to any M0/M1 request when FETCH_LAST=1.
- Undefined: fixed priority only; RR_PTR logic is absent.

Decomposition:
- Add to SH7604_PKG:
  - ArbState_t enum {IDLE, OWN}
  - Master index constants ARB_DMAC=0, ARB_CPUD=1, ARB_CPUI=2
  - ARB_NUM=3
- One sub-module, sh7604_arb_pick: a combinational winner selector (request vector, RR_PTR, mode) producing a one-hot result. It is instanced once.

Test Plan:
- Reset mid-grant: M1 granted with S_BUSY=1, pulse RST -> S_REQ=0, M_GNT=000, and M_BUSY=M_REQ immediately (asynchronous reset).
- Simultaneous request: M_REQ=111 from IDLE -> after one CE_R, M_GNT=001 and S_A=M0 address. After M0 completes, M_GNT=010 with no IDLE cycle, then 100.
- Locked RMW: M1 read with LOCK=1 at 0x0600_0000, M0 requests meanwhile -> M1 keeps the grant through the following write with LOCK=0. M0 is granted only on the edge that write completes, and M_BUSY[0]=1 throughout.
- Burst read: M2 BURST=1, WE=0, BURST_LEN=4, M1 requesting -> exactly 4 M2 completions, then M1 granted. A BURST=1/WE=1 request releases after 1 beat.
- Abort: M2 granted, S_BUSY=1, M2 drops REQ -> on the next CE_R, GNT moves to the pending M1 or to 000.
- SH7604_IBUS_ARB_RR_EN, FETCH_LAST=1, M0 and M1 requesting continuously -> grants alternate 001, 010, 001, 010. M2 is granted only when both are idle.

Source files
------------

// File: rtl/sh7604_ibus_arb_pkg.sv
// Shared types, constants and arbitration helpers for the SH7604 IBUS arbiter.
package sh7604_ibus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } ArbState_t;

    localparam int unsigned ARB_DMAC = 0;
    localparam int unsigned ARB_CPUD = 1;
    localparam int unsigned ARB_CPUI = 2;
    localparam int unsigned ARB_NUM  = 3;

    // Three-way rotating search; the scan runs far-to-near so the master nearest the pointer wins.
    function automatic logic [2:0] arb_rr3(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [2:0] idx;
        logic [1:0] start;
        res   = 3'b000;
        start = (ptr == 2'd3) ? 2'd0 : ptr;
        for (int k = 2; k >= 0; k--) begin
            idx = {1'b0, start} + 3'(k);
            idx = (idx >= 3'd3) ? (idx - 3'd3) : idx;
            res = req[idx[1:0]] ? (3'b001 << idx[1:0]) : res;
        end
        return res;
    endfunction

    // Pointer value just past the master whose grant is being released.
    function automatic logic [1:0] arb_rr_next(input logic [2:0] gnt, input logic fetch_last);
        logic [1:0] nxt;
        case (gnt)
            3'b001:  nxt = 2'd1;
            3'b010:  nxt = fetch_last ? 2'd0 : 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sh7604_arb_pick.sv
// Combinational winner selector: fixed M0>M1>M2 priority, or round-robin when rr_en is set.
module sh7604_arb_pick
    import sh7604_ibus_arb_pkg::*;
#(
    parameter bit FETCH_LAST = 1'b1
) (
    input  logic [ARB_NUM-1:0] req,
    input  logic [1:0]         rr_ptr,
    input  logic               rr_en,
    output logic [ARB_NUM-1:0] win
);

    // Winner selection; with FETCH_LAST only M0/M1 rotate and M2 takes what is left.
    always_comb begin
        win = 3'b000;
        if (rr_en && !FETCH_LAST) begin
            win = arb_rr3(req, rr_ptr);
        end else if (rr_en && (req[1:0] == 2'b11)) begin
            win = (rr_ptr == 2'd1) ? 3'b010 : 3'b001;
        end else if (req[ARB_DMAC]) begin
            win = 3'b001;
        end else if (req[ARB_CPUD]) begin
            win = 3'b010;
        end else if (req[ARB_CPUI]) begin
            win = 3'b100;
        end else begin
            win = 3'b000;
        end
    end

endmodule

// File: rtl/sh7604_ibus_arb.sv
// SH7604 IBUS arbiter: shares the BSC slave port between DMAC, CPU data and CPU fetch.
// Define SH7604_IBUS_ARB_RR_EN to enable round-robin arbitration (RR_PTR register).
module sh7604_ibus_arb
    import sh7604_ibus_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 4,
    parameter bit          FETCH_LAST = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic [95:0] M_A,
    input  logic [95:0] M_DI,
    input  logic [11:0] M_BA,
    input  logic [2:0]  M_WE,
    input  logic [2:0]  M_REQ,
    input  logic [2:0]  M_BURST,
    input  logic [2:0]  M_LOCK,
    output logic [31:0] M_DO,
    output logic [2:0]  M_BUSY,
    output logic [2:0]  M_GNT,
    output logic [31:0] S_A,
    output logic [31:0] S_DI,
    output logic [3:0]  S_BA,
    output logic        S_WE,
    output logic        S_REQ,
    output logic        S_BURST,
    output logic        S_LOCK,
    input  logic [31:0] S_DO,
    input  logic        S_BUSY
);

    localparam logic [1:0] BEAT_LAST = 2'(BURST_LEN - 1);

    ArbState_t          state_q, state_d;
    logic [ARB_NUM-1:0] gnt_q, gnt_d;
    logic [1:0]         beat_q, beat_d;
    logic               burst_q, burst_d;
    logic [1:0]         rr_ptr_s;
    logic               rr_en_s;
    logic [ARB_NUM-1:0] arb_req_s, win_s;
    logic [31:0]        s_a_s, s_di_s;
    logic [3:0]         s_ba_s;
    logic               g_req_s, g_lock_s, g_burst_s, g_we_s;
    logic               complete_s, release_s;

`ifdef SH7604_IBUS_ARB_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    assign rr_ptr_s = rr_ptr_q;
    assign rr_en_s  = 1'b1;
`else
    assign rr_ptr_s = 2'd0;
    assign rr_en_s  = 1'b0;
`endif

    // The request just served is consumed at its completion edge, so it does not compete again.
    assign arb_req_s = M_REQ & ~gnt_q;

    sh7604_arb_pick #(
        .FETCH_LAST (FETCH_LAST)
    ) u_pick (
        .req    (arb_req_s),
        .rr_ptr (rr_ptr_s),
        .rr_en  (rr_en_s),
        .win    (win_s)
    );

    // One-hot AND-OR mux of the granted master onto the slave port.
    always_comb begin
        s_a_s  = 32'h0000_0000;
        s_di_s = 32'h0000_0000;
        s_ba_s = 4'h0;
        for (int i = 0; i < ARB_NUM; i++) begin
            s_a_s  = s_a_s  | (M_A[32*i +: 32]  & {32{gnt_q[i]}});
            s_di_s = s_di_s | (M_DI[32*i +: 32] & {32{gnt_q[i]}});
            s_ba_s = s_ba_s | (M_BA[4*i +: 4]   & {4{gnt_q[i]}});
        end
    end

    assign g_req_s    = |(M_REQ & gnt_q);
    assign g_lock_s   = |(M_LOCK & gnt_q);
    assign g_burst_s  = |(M_BURST & gnt_q);
    assign g_we_s     = |(M_WE & gnt_q);
    assign complete_s = (state_q == OWN) && g_req_s && !S_BUSY;

    // Grant FSM next state: hold for lock or burst, otherwise re-arbitrate on completion or abort.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        beat_d    = beat_q;
        burst_d   = burst_q;
        release_s = 1'b0;
`ifdef SH7604_IBUS_ARB_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        if (CE_R) begin
            case (state_q)
                IDLE: begin
                    if (|M_REQ) begin
                        gnt_d   = win_s;
                        state_d = OWN;
                    end else begin
                        gnt_d   = 3'b000;
                    end
                end
                OWN: begin
                    if (complete_s) begin
                        if (g_lock_s) begin
                            gnt_d = gnt_q;
                        end else if ((burst_q || (g_burst_s && !g_we_s)) && (beat_q != BEAT_LAST)) begin
                            beat_d  = beat_q + 2'd1;
                            burst_d = 1'b1;
                        end else begin
                            release_s = 1'b1;
                        end
                    end else if (!g_req_s && !g_lock_s) begin
                        release_s = 1'b1;
                    end else begin
                        gnt_d = gnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = 3'b000;
                end
            endcase
            if (release_s) begin
                beat_d  = 2'd0;
                burst_d = 1'b0;
                gnt_d   = win_s;
                state_d = (|arb_req_s) ? OWN : IDLE;
`ifdef SH7604_IBUS_ARB_RR_EN
                rr_ptr_d = arb_rr_next(gnt_q, FETCH_LAST);
`endif
            end else begin
                beat_d = beat_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            gnt_q    <= 3'b000;
            beat_q   <= 2'd0;
            burst_q  <= 1'b0;
`ifdef SH7604_IBUS_ARB_RR_EN
            rr_ptr_q <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            beat_q   <= beat_d;
            burst_q  <= burst_d;
`ifdef SH7604_IBUS_ARB_RR_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign S_A     = s_a_s;
    assign S_DI    = s_di_s;
    assign S_BA    = s_ba_s;
    assign S_WE    = g_we_s;
    assign S_REQ   = g_req_s;
    assign S_BURST = g_burst_s;
    assign S_LOCK  = g_lock_s;
    assign M_DO    = S_DO;
    assign M_GNT   = gnt_q;
    assign M_BUSY  = M_REQ & (~gnt_q | {ARB_NUM{S_BUSY}});

endmodule

// File: tb/tb_sh7604_ibus_arb.sv
// Table-driven, scoreboarded bench for sh7604_ibus_arb (BURST_LEN=4, FETCH_LAST=1).
module tb_sh7604_ibus_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CE_R;
    logic [95:0] M_A, M_DI;
    logic [11:0] M_BA;
    logic [2:0]  M_WE, M_REQ, M_BURST, M_LOCK;
    logic [31:0] M_DO;
    logic [2:0]  M_BUSY, M_GNT;
    logic [31:0] S_A, S_DI;
    logic [3:0]  S_BA;
    logic        S_WE, S_REQ, S_BURST, S_LOCK;
    logic [31:0] S_DO;
    logic        S_BUSY;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0600_0000;
    localparam logic [31:0] A2 = 32'h0000_2000;

    typedef struct packed {
        logic       ce;
        logic [2:0] req, burst, lock, we;
        logic       sbusy;
        logic [2:0] egnt, ebusy;
        logic       esreq;
    } vec_t;

    typedef struct packed {
        logic [2:0]  gnt, busy;
        logic        sreq;
        logic [31:0] sa;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    sh7604_ibus_arb #(.BURST_LEN(4), .FETCH_LAST(1'b1)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R),
        .M_A(M_A), .M_DI(M_DI), .M_BA(M_BA), .M_WE(M_WE), .M_REQ(M_REQ),
        .M_BURST(M_BURST), .M_LOCK(M_LOCK), .M_DO(M_DO), .M_BUSY(M_BUSY), .M_GNT(M_GNT),
        .S_A(S_A), .S_DI(S_DI), .S_BA(S_BA), .S_WE(S_WE), .S_REQ(S_REQ),
        .S_BURST(S_BURST), .S_LOCK(S_LOCK), .S_DO(S_DO), .S_BUSY(S_BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return A0;
            3'b010:  return A1;
            3'b100:  return A2;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ce, input logic [2:0] req, input logic [2:0] burst,
                       input logic [2:0] lock, input logic [2:0] we, input logic sbusy,
                       input logic [2:0] egnt, input logic [2:0] ebusy, input logic esreq);
        vecs.push_back({ce, req, burst, lock, we, sbusy, egnt, ebusy, esreq});
    endtask

    task automatic drive(input vec_t v);
        CE_R    = v.ce;
        M_REQ   = v.req;
        M_BURST = v.burst;
        M_LOCK  = v.lock;
        M_WE    = v.we;
        S_BUSY  = v.sbusy;
    endtask

    initial begin
        exp_t e;
        vec_t v;
        // ce  req     burst   lock    we      sb    gnt     busy    sreq
        add(1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 3'b001, 3'b110, 1'b1); // simultaneous: M0 first
        add(1, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 3'b010, 3'b101, 1'b1); // back-to-back M1
        add(1, 3'b110, 3'b000, 3'b000, 3'b000, 1'b0, 3'b100, 3'b010, 1'b1); // then M2
        add(1, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b100, 1'b0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(0, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0); // CE_R low: no grant
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 3'b010, 1'b1);
        add(1, 3'b011, 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 3'b011, 1'b1); // new M0 waits
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 3'b001, 3'b001, 1'b1); // M1 abort -> M0
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b000, 1'b1); // locked read
        add(1, 3'b011, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b001, 1'b1);
        add(1, 3'b011, 3'b000, 3'b000, 3'b010, 1'b1, 3'b010, 3'b011, 1'b1); // write, stalled
        add(1, 3'b011, 3'b000, 3'b000, 3'b010, 1'b0, 3'b001, 3'b010, 1'b1); // write done -> M0
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b001, 1'b0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1, 3'b100, 3'b100, 3'b000, 3'b000, 1'b1, 3'b100, 3'b100, 1'b1); // M2 burst read
        add(1, 3'b110, 3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 3'b010, 1'b1); // beat 1
        add(1, 3'b110, 3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 3'b010, 1'b1); // beat 2
        add(1, 3'b110, 3'b100, 3'b000, 3'b000, 1'b0, 3'b100, 3'b010, 1'b1); // beat 3
        add(1, 3'b110, 3'b100, 3'b000, 3'b000, 1'b0, 3'b010, 3'b100, 1'b1); // beat 4 -> M1
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1, 3'b100, 3'b100, 3'b000, 3'b100, 1'b0, 3'b100, 3'b000, 1'b1); // burst write
        add(1, 3'b110, 3'b100, 3'b000, 3'b100, 1'b0, 3'b010, 3'b100, 1'b1); // single beat only
        add(1, 3'b010, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b010, 1'b0);
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0);
        add(1, 3'b010, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b000, 1'b1);
        add(1, 3'b000, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b000, 1'b0); // idle locked bus
        add(1, 3'b001, 3'b000, 3'b010, 3'b000, 1'b0, 3'b010, 3'b001, 1'b0);
        add(1, 3'b001, 3'b000, 3'b000, 3'b000, 1'b0, 3'b001, 3'b000, 1'b1); // unlock -> M0
        add(1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 3'b000, 3'b000, 1'b0); // M0 abort -> IDLE

        M_A     = {A2, A1, A0};
        M_DI    = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        M_BA    = 12'hFFF;
        M_WE    = 3'b000;
        M_BURST = 3'b000;
        M_LOCK  = 3'b000;
        M_REQ   = 3'b101;
        S_DO    = 32'hCAFE_0001;
        S_BUSY  = 1'b0;
        CE_R    = 1'b1;
        RST     = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("reset gnt", {29'd0, M_GNT}, 32'd0);
        check("reset sreq", {31'd0, S_REQ}, 32'd0);
        check("reset busy", {29'd0, M_BUSY}, {29'd0, 3'b101});
        check("reset s_a", S_A, 32'h0000_0000);
        check("m_do", M_DO, 32'hCAFE_0001);
        M_REQ = 3'b000;
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v);
            sb.push_back({v.egnt, v.ebusy, v.esreq, addr_of(v.egnt)});
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d gnt", i), {29'd0, M_GNT}, {29'd0, e.gnt});
            check($sformatf("v%0d busy", i), {29'd0, M_BUSY}, {29'd0, e.busy});
            check($sformatf("v%0d sreq", i), {31'd0, S_REQ}, {31'd0, e.sreq});
            check($sformatf("v%0d s_a", i), S_A, e.sa);
        end

        // Asynchronous reset while M1 owns a stalled transfer.
        CE_R = 1'b1; M_REQ = 3'b010; M_LOCK = 3'b000; M_BURST = 3'b000; M_WE = 3'b000; S_BUSY = 1'b1;
        @(posedge CLK);
        #1;
        check("pre-reset gnt", {29'd0, M_GNT}, {29'd0, 3'b010});
        #2;
        RST = 1'b1;
        #1;
        check("async rst gnt", {29'd0, M_GNT}, 32'd0);
        check("async rst sreq", {31'd0, S_REQ}, 32'd0);
        check("async rst busy", {29'd0, M_BUSY}, {29'd0, 3'b010});
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("post-reset gnt", {29'd0, M_GNT}, {29'd0, 3'b010});
        check("post-reset s_a", S_A, A1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
